bp_me_axi_write_sink: RTL
=========================

# bp_me_axi_write_sink

Downstream companion to the AXI transfer-address pump. It pairs each per-transfer address/mask beat from the pump with one W-channel beat, merges the pump byte-lane mask with WSTRB, and emits a registered write request to the memory side. After the last beat of a burst has been accepted by memory, it returns the B response.

## Interface
- `axi_addr_width_p`, 64, address width; matches the pump.
- `axi_data_width_p`, 64, W data width; the mask width is `axi_data_width_p/8`.
- `axi_id_width_p`, 6, width of the BID/AWID field.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `pump_v_i`  in  1  pump has a valid transfer address.
- `pump_send_o`  out  1  consume the current pump transfer; asserted exactly when a W beat is accepted.
- `pump_addr_i`  in  `axi_addr_width_p`  transfer address.
- `pump_mask_i`  in  `axi_data_width_p/8`  legal byte lanes for this transfer.
- `pump_first_i`  in  1  first transfer of the burst.
- `pump_last_i`  in  1  last transfer of the burst.
- `awid_i`  in  `axi_id_width_p`  ID of the burst, stable while `pump_v_i`.
- `s_axi_wvalid_i`  in  1  W beat valid.
- `s_axi_wready_o`  out  1  W beat ready.
- `s_axi_wdata_i`  in  `axi_data_width_p`  W data.
- `s_axi_wstrb_i`  in  `axi_data_width_p/8`  W strobes.
- `s_axi_wlast_i`  in  1  W last.
- `mem_v_o`  out  1  registered write request valid.
- `mem_ready_and_i`  in  1  memory accepts the request.
- `mem_addr_o`  out  `axi_addr_width_p`  write address.
- `mem_data_o`  out  `axi_data_width_p`  write data, passed through unshifted.
- `mem_mask_o`  out  `axi_data_width_p/8`  byte enables, equal to `wstrb & pump_mask`.
- `mem_last_o`  out  1  final request of the burst.
- `s_axi_bvalid_o`  out  1  B response valid.
- `s_axi_bready_i`  in  1  B response ready.
- `s_axi_bid_o`  out  `axi_id_width_p`  response ID.
- `s_axi_bresp_o`  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR.

## Operation
- **State machine:** `e_data` → `e_drain` → `e_resp` → `e_data`. The reset state is `e_data`.
- **e_data:**
  - `s_axi_wready_o = pump_v_i & (~mem_v_o | mem_ready_and_i)`.
  - Define `accept_w = wvalid & wready`; then `pump_send_o = accept_w`.
  - On `accept_w`, the output register loads addr, data, merged mask and `mem_last = pump_last_i`.
  - On `accept_w & pump_first_i`, capture `awid_i` into `bid_r`.
  - On `accept_w & pump_last_i`, go to `e_drain`.
- **e_drain:**
  - W is not ready.
  - Move to `e_resp` once the output register is empty, or is emptying this cycle (`~mem_v_o | mem_ready_and_i`).
- **e_resp:**
  - `s_axi_bvalid_o = 1`, with `bid = bid_r` and `bresp = err_r ? 2'b10 : 2'b00`.
  - On `bready`, return to `e_data` and clear `err_r`.
- **Output register:**
  - One entry.
  - `mem_v_o` is set on `accept_w` and cleared on `mem_ready_and_i` when no new beat loads in the same cycle.
  - Load and drain in the same cycle keeps `mem_v_o = 1` with the new contents.
- **Zero-strobe beat:** a beat whose merged mask is all zero is still forwarded to memory with mask 0. It still counts as a transfer.
- **Input capture:** pump fields are sampled only on `accept_w`. They are never registered ahead of the W beat.

## Timing
- **Reset values:** `mem_v_o = 0`, `s_axi_bvalid_o = 0`, `s_axi_wready_o = 0`, `pump_send_o = 0`, `s_axi_bresp_o = 0`, `s_axi_bid_o = 0`. Data and addr outputs are don't-care.
- **Request latency:** a W beat accepted in cycle N appears on `mem_*` in cycle N+1.
- **Throughput:** one beat per cycle while memory is continuously ready.
- **B latency:** the earliest `bvalid` is 2 cycles after the last W accept:
  - cycle N+1: memory accepts the last request; the FSM is in `e_drain` and exits.
  - cycle N+2: `e_resp`.
- **Handshake rules:**
  - `bvalid` holds until `bready`.
  - `mem_v_o` and its payload are held stable until `mem_ready_and_i`.
  - `wready` has no combinational dependence on `wvalid`.
- **Reset mid-burst:** any in-flight request and any pending response are discarded.
- **Next burst:** no W beat of the next burst is accepted before the B handshake completes.

## Configuration
- Macro: `BP_ME_AXI_WRITE_SINK_WLAST_CHECK_EN`.
- **Defined:**
  - On `accept_w`, if `s_axi_wlast_i != pump_last_i`, set sticky `err_r`; the burst then completes with SLVERR.
  - An early `wlast` does not terminate the burst. Termination always follows `pump_last_i`.
- **Undefined:**
  - `s_axi_wlast_i` is ignored.
  - `err_r` is constantly 0, so BRESP is always OKAY.

## Test plan
- **Single beat:** INCR len 0 at addr 0x1003, size 0, wstrb 0xFF.
  - `mem_addr_o = 0x1003` and `mem_mask_o = 0x08` in cycle N+1.
  - `bvalid` in N+2 with BRESP 0.
- **Full-rate burst:** 4-beat burst at 0x2000, size 3, memory always ready.
  - Four consecutive `mem_v_o` cycles at addresses 0x2000, 0x2008, 0x2010, 0x2018.
  - `mem_last_o` on the 4th only.
  - BID equals the captured AWID 0x15.
- **Memory backpressure:** `mem_ready_and_i` low for 3 cycles mid-burst.
  - `wready` stays low until the register drains.
  - No beat is lost or duplicated; the payload is stable throughout.
- **B backpressure:** `bready` held low 5 cycles.
  - `bvalid` and `bid` are held.
  - `wready` stays 0 even though the next burst has `pump_v_i = 1` and `wvalid = 1`.
- **WLAST mismatch:** with the macro defined, send `wlast = 1` on beat 2 of 4.
  - All 4 beats are still forwarded; BRESP = 2'b10.
  - With the macro undefined, BRESP = 2'b00.
- **Reset mid-burst:** assert reset after beat 1 of 4.
  - Next cycle: `mem_v_o = 0`, `bvalid = 0`, state `e_data`.
  - A new burst then completes normally.

Source files
------------

// File: rtl/bp_me_axi_write_sink.sv
// bp_me_axi_write_sink: pairs pump transfer beats with AXI W beats and
// issues one registered memory write per beat, then returns the B response.
// Ports: clk_i/reset_i (sync, active-high); pump_* transfer address/mask in,
// pump_send_o consume; s_axi_w* W channel; mem_* registered write request;
// s_axi_b* B channel. Macro BP_ME_AXI_WRITE_SINK_WLAST_CHECK_EN enables the
// WLAST vs pump_last consistency check (mismatch -> SLVERR).
module bp_me_axi_write_sink
  #(parameter int axi_addr_width_p = 64
  , parameter int axi_data_width_p = 64
  , parameter int axi_id_width_p = 6
  , localparam int mask_width_lp = axi_data_width_p/8
  )
  (input  logic                        clk_i
  , input  logic                        reset_i

  , input  logic                        pump_v_i
  , output logic                        pump_send_o
  , input  logic [axi_addr_width_p-1:0] pump_addr_i
  , input  logic [mask_width_lp-1:0]    pump_mask_i
  , input  logic                        pump_first_i
  , input  logic                        pump_last_i
  , input  logic [axi_id_width_p-1:0]   awid_i

  , input  logic                        s_axi_wvalid_i
  , output logic                        s_axi_wready_o
  , input  logic [axi_data_width_p-1:0] s_axi_wdata_i
  , input  logic [mask_width_lp-1:0]    s_axi_wstrb_i
  , input  logic                        s_axi_wlast_i

  , output logic                        mem_v_o
  , input  logic                        mem_ready_and_i
  , output logic [axi_addr_width_p-1:0] mem_addr_o
  , output logic [axi_data_width_p-1:0] mem_data_o
  , output logic [mask_width_lp-1:0]    mem_mask_o
  , output logic                        mem_last_o

  , output logic                        s_axi_bvalid_o
  , input  logic                        s_axi_bready_i
  , output logic [axi_id_width_p-1:0]   s_axi_bid_o
  , output logic [1:0]                  s_axi_bresp_o
  );

  typedef enum logic [1:0] {
    e_data  = 2'd0,
    e_drain = 2'd1,
    e_resp  = 2'd2
  } state_e;

  state_e                        state_r;
  logic                          mem_v_r;
  logic [axi_addr_width_p-1:0]   addr_r;
  logic [axi_data_width_p-1:0]   data_r;
  logic [mask_width_lp-1:0]      mask_r;
  logic                          last_r;
  logic [axi_id_width_p-1:0]     bid_r;
  logic                          err_r;

  logic mem_free;
  logic accept_w;
  logic err_set;

  // Output slot can take a beat if empty or being drained this cycle.
  assign mem_free = ~mem_v_r | mem_ready_and_i;

  assign s_axi_wready_o = ~reset_i
                        & (state_r == e_data)
                        & pump_v_i
                        & mem_free;

  assign accept_w    = s_axi_wvalid_i & s_axi_wready_o;
  assign pump_send_o = accept_w;

`ifdef BP_ME_AXI_WRITE_SINK_WLAST_CHECK_EN
  assign err_set = accept_w & (s_axi_wlast_i != pump_last_i);
`else
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast_i;
  assign err_set      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_data;
      mem_v_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      mask_r  <= '0;
      last_r  <= 1'b0;
      bid_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      if (accept_w) begin
        mem_v_r <= 1'b1;
        addr_r  <= pump_addr_i;
        data_r  <= s_axi_wdata_i;
        mask_r  <= s_axi_wstrb_i & pump_mask_i;
        last_r  <= pump_last_i;
        if (pump_first_i)
          bid_r <= awid_i;
      end else if (mem_ready_and_i) begin
        mem_v_r <= 1'b0;
      end

      if (err_set)
        err_r <= 1'b1;

      unique case (state_r)
        e_data:
          if (accept_w & pump_last_i)
            state_r <= e_drain;
        e_drain:
          if (mem_free)
            state_r <= e_resp;
        e_resp:
          if (s_axi_bready_i) begin
            state_r <= e_data;
            err_r   <= 1'b0;
          end
        default:
          state_r <= e_data;
      endcase
    end
  end

  assign mem_v_o    = mem_v_r;
  assign mem_addr_o = addr_r;
  assign mem_data_o = data_r;
  assign mem_mask_o = mask_r;
  assign mem_last_o = last_r;

  assign s_axi_bvalid_o = (state_r == e_resp);
  assign s_axi_bid_o    = bid_r;
  assign s_axi_bresp_o  = {err_r & s_axi_bvalid_o, 1'b0};

endmodule
